// File: rtl/systolic_ctrl_if.sv
// Result-drain handshake between the systolic array controller and its consumer.
// The controller presents one accumulator per cycle; the consumer paces it with res_ready.
interface systolic_ctrl_if;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] res_idx;

    modport master (
        output res_valid,
        output res_data,
        output res_idx,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_idx,
        output res_ready
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N output-stationary systolic MAC array: skewed operand feed,
// wavefront flush, then a handshaked drain of every accumulator through the PE chain.
module systolic_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    feed_en,
    output logic [N*KW-1:0] feed_k,
    output logic            chain_en,
    input  logic [7:0]      chain_tail,
    systolic_ctrl_if.master res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Extended width so K + 2N - 3 and the i + K window bound never wrap.
    localparam int         EW     = KW + 7;
    localparam logic [7:0] M_LAST = 8'(N * N - 1);

    state_t        state, state_nxt;
    logic [KW:0]   t, t_nxt;
    logic [7:0]    m, m_nxt;
    logic [KW-1:0] k_reg, k_nxt;

    logic [EW-1:0] t_ext;
    logic [EW-1:0] k_ext;
    logic [EW-1:0] t_last;
    logic          in_drain;

    assign t_ext  = EW'(t);
    assign k_ext  = EW'(k_reg);
    assign t_last = k_ext + EW'(2 * N - 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= '0;
            m     <= '0;
            k_reg <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            m     <= m_nxt;
            k_reg <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        m_nxt     = m;
        k_nxt     = k_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    k_nxt     = k_len;
                    t_nxt     = '0;
                    m_nxt     = '0;
                    state_nxt = (k_len == '0) ? DRAIN : FEED;
                end
            end
            FEED: begin
                t_nxt = t + 1'b1;
                if (t_ext == t_last) begin
                    state_nxt = DRAIN;
                    m_nxt     = '0;
                end
            end
            DRAIN: begin
                if (res.res_ready) begin
                    m_nxt = m + 8'd1;
                    if (m == M_LAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row/column i sees step t-i while inside its K-long window; the feeder zeroes outside it.
    always_comb begin
        feed_en = '0;
        feed_k  = '0;
        if (state == FEED) begin
            for (int i = 0; i < N; i++) begin
                if ((t_ext >= EW'(i)) && (t_ext < EW'(i) + k_ext)) begin
                    feed_en[i]           = 1'b1;
                    feed_k[i*KW +: KW]   = KW'(t_ext - EW'(i));
                end
            end
        end
    end

    assign in_drain      = (state == DRAIN);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign res.res_valid = in_drain;
    assign res.res_idx   = in_drain ? m : 8'd0;
    assign res.res_data  = chain_tail;
    // Stalled cycles leave the chain still; the zero operands keep accumulators intact.
    assign chain_en      = in_drain & res.res_ready;

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for an N×N output-stationary systolic array of MAC processing elements. It runs one matrix-multiply job per `start`:
- schedules skewed operand feeding into the array's west (A) and north (B) edges for `k_len` inner-dimension steps;
- waits for the wavefront to reach the far corner;
- drains all N×N accumulators through the PE readout chain under a valid/ready handshake.

It sits between the operand buffers/feeders and the array wrapper.

## Interface
Parameters:
- `N`, default 4: array dimension, 2..16.
- `KW`, default 8: width of `k_len` and of the per-row step index.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low. The same net resets the PEs.
- `start`, in, 1: job request. Sampled only in IDLE.
- `k_len`, in, KW: inner-dimension length K. Captured when `start` is accepted.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse at the end of the job.
- `feed_en`, out, N: bit i enables A row i and B column i this cycle. When the bit is low, the feeder drives 0.
- `feed_k`, out, N*KW: slice `[i*KW +: KW]` is the step index for row/column i. It is 0 when `feed_en[i]` is low.
- `chain_en`, out, 1: drives every PE's chain-shift enable.
- `chain_tail`, in, 8: `out_c` of chain tail PE(N-1,N-1).
- `res_valid`, out, 1: a result is presented.
- `res_ready`, in, 1: the consumer accepts the result.
- `res_data`, out, 8: the result value, equal to `chain_tail`.
- `res_idx`, out, 8: ordinal of the presented result, 0..N*N-1.

## Operation
- **States**
  - IDLE → FEED on `start`. If the captured K is 0, IDLE → DRAIN instead.
  - FEED → DRAIN after the last FEED cycle.
  - DRAIN → DONE after N*N handshakes.
  - DONE → IDLE unconditionally, after 1 cycle.
- **FEED**
  - Step counter t, width KW+1, runs 0..K+2N-3. FEED therefore lasts K+2N-2 cycles.
  - `feed_en[i]` = (t ≥ i) && (t < i+K).
  - `feed_k[i]` = t−i, truncated to KW bits, whenever enabled.
  - Rationale: with one-cycle pass-through registers per PE, step k reaches PE(i,j) at t = k+i+j on both operands. The last product lands at t = K+2N-3.
- **DRAIN**
  - `res_valid` = 1 and `chain_en` = `res_valid` && `res_ready`, which is combinational.
  - `feed_en` is all 0, so any stall cycle (chain_en low) performs a MAC of 0×0. Accumulators are therefore unchanged during backpressure.
  - The result counter m starts at 0 on DRAIN entry, is output as `res_idx`, and increments on each handshake.
  - Leave DRAIN on the handshake where m = N*N-1.
- **Chain contract for the array wrapper**
  - The chain runs row-major from PE(0,0) to PE(N-1,N-1).
  - PE(0,0) `chain_in` is tied to 0.
  - Result m is the accumulator of linear PE index N*N-1-m.
  - After a full drain every accumulator is 0. This is the required pre-condition for the next job; reset also establishes it.
- **Arithmetic** is 8-bit wrap in the PEs, and the controller does not modify data.
- **Start handling**
  - `start` outside IDLE is ignored and is not queued.
  - `start` held high continuously launches a new job on the cycle after the DONE cycle, i.e. from IDLE.

## Timing
- **Reset:** asynchronous assertion forces IDLE, with t = 0 and m = 0. All outputs become 0: `busy`, `done`, `feed_en`, `feed_k`, `chain_en`, `res_valid` and `res_idx` are 0; `res_data` follows `chain_tail`, which is 0 because the PEs are reset by the same net. This holds mid-job: the job is abandoned and the next `start` after deassertion begins a fresh job.
- **Register/decode split:** state, t, m and the captured K are registered. `feed_en`, `feed_k`, `busy`, `res_valid`, `res_idx` and `done` are decoded from those registers, with no added latency.
- **Start latency:** `start` high at clock edge E0 while in IDLE → the first FEED cycle follows E0, with `feed_en[0]` = 1 and `feed_k[0]` = 0.
- **First result:** the first DRAIN cycle is FEED cycle count + 1 cycles after E0, i.e. K+2N-1. The first `res_valid` appears then.
- **Handshake:** one result per cycle at full throughput. `res_data`, `res_idx` and `res_valid` must stay stable while `res_ready` is low.
- **Done:** `done` is high for exactly one cycle, in DONE, which is the cycle after the last handshake. `busy` is still high in that cycle.
- **Minimum job length:** K+2N-2 + N*N + 1 cycles of `busy`.

## Test plan
- **Basic job, N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:**
  - FEED lasts 4 cycles; `feed_en` = 01, 11, 10, 00.
  - Results in order are 50, 43, 22, 19, with `res_idx` 0..3.
  - `done` pulses one cycle later.
- **Backpressure, same job, `res_ready` toggled 1,0,0,1,0,1,1:**
  - Identical values and order.
  - `chain_en` is high only on handshake cycles.
  - Outputs are held while stalled.
- **K=0 start:**
  - DRAIN begins on the first cycle after the start edge.
  - 4 results, all 0.
  - `done` pulses; no `feed_en` ever asserts.
- **Start pulses during FEED and DRAIN, and start held high:**
  - Mid-job starts are ignored.
  - The held start begins the next job exactly 1 cycle after the DONE cycle.
- **Reset mid-job, `rst_n` low at t=2 of FEED:**
  - All outputs are 0 immediately.
  - A following job with K=2 gives the exact results of the basic-job scenario, showing no residue.
- **Long K, N=4, K=255, all operands 1:**
  - t reaches 260 without overflow.
  - `feed_k[3]` runs 0..254.
  - All 16 results are 255.
